// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared opcodes, FSM states, datapath select encodings and control word for the multi-cycle MIPS controller
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_ORI = 6'b001101;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC,
    S_R_WB,
    S_BRANCH,
    S_JUMP,
    S_IMM_EXEC,
    S_IMM_WB
  } state_t;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  localparam logic [1:0] SRC_B_RT     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
  localparam logic [1:0] WB_SEL_MDR    = 2'b01;
  localparam logic [1:0] WB_SEL_LUI    = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_LUI, OP_ORI};
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state + opcode + memory-ready to control word decoder
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     i_state,
  input  logic [5:0] i_opcode,
  input  logic       i_rdy,
  output ctrl_t      o_ctrl
);

  logic w_illegal;

  assign w_illegal = !is_legal(i_opcode);

  // Every field defaults to 0, so only the strobes and selects each state needs are raised
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRC_B_FOUR;
        o_ctrl.ir_write  = i_rdy;
        o_ctrl.pc_write  = i_rdy;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b  = SRC_B_IMM_SH;
        o_ctrl.illegal_op = w_illegal;
        o_ctrl.instr_done = w_illegal;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = WB_SEL_MDR;
        o_ctrl.instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write  = 1'b1;
        o_ctrl.i_or_d     = 1'b1;
        o_ctrl.instr_done = i_rdy;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRC_B_RT;
        o_ctrl.alu_op    = ALU_OP_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.reg_dst    = 1'b1;
        o_ctrl.mem_to_reg = WB_SEL_ALUOUT;
        o_ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRC_B_RT;
        o_ctrl.alu_op        = ALU_OP_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PC_SRC_ALUOUT;
        o_ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PC_SRC_JUMP;
        o_ctrl.instr_done = 1'b1;
      end
      S_IMM_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRC_B_IMM;
        o_ctrl.alu_op    = ALU_OP_OR;
      end
      S_IMM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = (i_opcode == OP_LUI) ? WB_SEL_LUI : WB_SEL_ALUOUT;
        o_ctrl.instr_done = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// multi_cycle_control: main multi-cycle MIPS control FSM; holds the state register and next-state logic
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op
);

  state_t r_state;
  state_t w_state_nxt;
  logic   w_rdy;
  ctrl_t  w_ctrl;

  assign w_rdy = USE_MEM_READY ? mem_ready : 1'b1;

  // Memory states hold on !rdy; every final state returns to FETCH
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      w_state_nxt = S_FETCH;
      S_FETCH:     w_state_nxt = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_state_nxt = S_MEM_ADDR;
          OP_R:         w_state_nxt = S_EXEC;
          OP_BEQ:       w_state_nxt = S_BRANCH;
          OP_J:         w_state_nxt = S_JUMP;
          OP_ORI:       w_state_nxt = S_IMM_EXEC;
          OP_LUI:       w_state_nxt = S_IMM_WB;
          default:      w_state_nxt = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  w_state_nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  w_state_nxt = w_rdy ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: w_state_nxt = w_rdy ? S_FETCH : S_MEM_WRITE;
      S_EXEC:      w_state_nxt = S_R_WB;
      S_IMM_EXEC:  w_state_nxt = S_IMM_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_IMM_WB: w_state_nxt = S_FETCH;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Asynchronous reset drops straight to IDLE so no partially issued write completes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  mc_ctrl_decode u_decode (
    .i_state  (r_state),
    .i_opcode (opcode),
    .i_rdy    (w_rdy),
    .o_ctrl   (w_ctrl)
  );

  assign pc_write      = w_ctrl.pc_write;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign ir_write      = w_ctrl.ir_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign instr_done    = w_ctrl.instr_done;
  assign illegal_op    = w_ctrl.illegal_op;

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control: scoreboard bench comparing every cycle's control word against per-instruction expected sequences
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0] mem_to_reg;
  logic       reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       instr_done, illegal_op;
  logic [18:0] w_obs;

  logic [18:0] q_exp[$];
  logic        q_rdy[$];
  logic [5:0]  q_op[$];
  string       q_tag[$];
  int checks = 0;
  int errors = 0;

  multi_cycle_control #(.USE_MEM_READY(1'b1)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .instr_done    (instr_done),
    .illegal_op    (illegal_op)
  );

  always #5 clk = ~clk;

  assign w_obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                  reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};

  task automatic chk(input string tag, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic logic [18:0] mk(input logic pw, pwc, iod, mr, mw, irw, input logic [1:0] m2r,
                                     input logic rd, rw, sa, input logic [1:0] sb, aop, ps,
                                     input logic done, ill);
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, aop, ps, done, ill};
  endfunction

  task automatic push(input string tag, input logic [5:0] op, input logic rdy, input logic [18:0] e);
    q_tag.push_back(tag);
    q_op.push_back(op);
    q_rdy.push_back(rdy);
    q_exp.push_back(e);
  endtask

  task automatic push_instr(input string name, input logic [5:0] op, input int fw, input int mw);
    logic legal;
    legal = op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001111, 6'b001101};
    for (int i = 0; i < fw; i++)
      push({name, "_fetch_wait"}, 6'($urandom), 1'b0,
           mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0));
    push({name, "_fetch"}, 6'($urandom), 1'b1,
         mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0));
    push({name, "_decode"}, op, 1'($urandom_range(0, 1)),
         mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,!legal,!legal));
    case (op)
      6'b100011, 6'b101011: begin
        push({name, "_mem_addr"}, op, 1'($urandom_range(0, 1)),
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0));
        if (op == 6'b100011) begin
          for (int i = 0; i <= mw; i++)
            push({name, "_mem_read"}, op, i == mw,
                 mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0));
          push({name, "_mem_wb"}, op, 1'($urandom_range(0, 1)),
               mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0));
        end else begin
          for (int i = 0; i <= mw; i++)
            push({name, "_mem_write"}, op, i == mw,
                 mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,i == mw,1'b0));
        end
      end
      6'b000000: begin
        push({name, "_exec"}, op, 1'($urandom_range(0, 1)),
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0));
        push({name, "_r_wb"}, op, 1'($urandom_range(0, 1)),
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0));
      end
      6'b000100:
        push({name, "_branch"}, op, 1'($urandom_range(0, 1)),
             mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0));
      6'b000010:
        push({name, "_jump"}, op, 1'($urandom_range(0, 1)),
             mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0));
      6'b001101: begin
        push({name, "_imm_exec"}, op, 1'($urandom_range(0, 1)),
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,2'b10,2'b11,2'b00,1'b0,1'b0));
        push({name, "_imm_wb"}, op, 1'($urandom_range(0, 1)),
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0));
      end
      6'b001111:
        push({name, "_imm_wb"}, op, 1'($urandom_range(0, 1)),
             mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0));
      default: ;
    endcase
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n && q_exp.size() > 0; i++) begin
      @(posedge clk);
      #1;
      opcode    = q_op.pop_front();
      mem_ready = q_rdy.pop_front();
      @(negedge clk);
      chk(q_tag.pop_front(), w_obs, q_exp.pop_front());
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset", w_obs, 19'd0);
    #1;
    rstn = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("idle", w_obs, 19'd0);
    push_instr("lw", 6'b100011, 0, 0);
    push_instr("r", 6'b000000, 0, 0);
    push_instr("ori", 6'b001101, 0, 0);
    push_instr("sw", 6'b101011, 0, 3);
    push_instr("beq", 6'b000100, 0, 0);
    push_instr("j", 6'b000010, 0, 0);
    push_instr("lui", 6'b001111, 0, 0);
    push_instr("ill", 6'b111111, 0, 0);
    push_instr("j2", 6'b000010, 0, 0);
    push_instr("lw_wait", 6'b100011, 2, 1);
    run(q_exp.size());
    push_instr("lw_rst", 6'b100011, 0, 6);
    run(4);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_rst", w_obs, 19'd0);
    q_exp.delete();
    q_rdy.delete();
    q_op.delete();
    q_tag.delete();
    @(negedge clk);
    chk("rst_hold", w_obs, 19'd0);
    #1;
    rstn = 1'b1;
    #1;
    chk("idle_after_rst", w_obs, 19'd0);
    push_instr("lw_post", 6'b100011, 0, 0);
    run(q_exp.size());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
